// File: rtl/b_dly_pkg.sv
// Shared definitions for the delay-line lock controller: code width,
// reset code, FSM state and update-direction encodings.
package b_dly_pkg;

    localparam int                CODE_W   = 9;
    localparam logic [CODE_W-1:0] CODE_RST = 9'd256;
    localparam logic [CODE_W-1:0] CODE_MAX = 9'd511;

    // Vote filter width: holds -15..+15, enough for any threshold up to 15.
    localparam int FILT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    // A reversal needs a previous update to compare against.
    function automatic logic is_reversal(input dir_t last, input dir_t now);
        return (last != DIR_NONE) && (last != now);
    endfunction

endpackage

// File: rtl/b_dly_vote_filt.sv
// Signed phase-detector vote filter. Emits a one-cycle inc/dec pulse on the
// edge where the running sum would reach +/-P_TH and restarts from zero.
module b_dly_vote_filt
    import b_dly_pkg::*;
#(
    parameter int P_TH = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_up,
    input  logic i_dn,
    input  logic i_clr,
    output logic o_inc,
    output logic o_dec
);

    localparam logic signed [FILT_W-1:0] TH_POS = P_TH[FILT_W-1:0];
    localparam logic signed [FILT_W-1:0] TH_NEG = -TH_POS;

    logic signed [FILT_W-1:0] filt_q, filt_d, vote, sum;

    // Net vote: simultaneous up and dn cancel out.
    always_comb begin
        vote = '0;
        case ({i_up, i_dn})
            2'b10:   vote = 5'sd1;
            2'b01:   vote = -5'sd1;
            default: vote = '0;
        endcase
    end

    assign sum   = filt_q + vote;
    assign o_inc = ~i_clr & (sum == TH_POS);
    assign o_dec = ~i_clr & (sum == TH_NEG);

    // Next filter value: cleared on request or whenever an update fires.
    always_comb begin
        filt_d = sum;
        if (i_clr || o_inc || o_dec) begin
            filt_d = '0;
        end
    end

    // Filter register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/b_dly_lock_ctrl.sv
// Delay-line lock controller: filters phase-detector votes into code updates,
// coarse steps during acquisition, unit steps while tracking, and declares
// lock after enough consecutive direction reversals.
// Optional feature macro: DLY_LOCK_CTRL_OVRD_EN adds a direct code override.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | loop disabled; code held, filter/count/lock/sat cleared
// ST_ACQ   | acquisition; updates move the code by P_ACQ_STEP
// ST_TRACK | tracking; updates move the code by 1, reversals counted
module b_dly_lock_ctrl
    import b_dly_pkg::*;
#(
    parameter int P_FILT_TH  = 4,
    parameter int P_ACQ_STEP = 8,
    parameter int P_LOCK_REV = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [CODE_W-1:0] i_init_code,
    input  logic              i_pd_up,
    input  logic              i_pd_dn,
`ifdef DLY_LOCK_CTRL_OVRD_EN
    input  logic              i_ovrd_en,
    input  logic [CODE_W-1:0] i_ovrd_code,
`endif
    output logic [CODE_W-1:0] o_dly_sel,
    output logic              o_lock,
    output logic              o_sat_hi,
    output logic              o_sat_lo
);

    localparam logic [CODE_W-1:0] STEP_ACQ = P_ACQ_STEP[CODE_W-1:0];
    localparam logic [CODE_W-1:0] STEP_ONE = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        LOCK_REV = P_LOCK_REV[3:0];

    state_t            state_q, state_d;
    dir_t              dir_q, dir_d, new_dir;
    logic [CODE_W-1:0] code_q, code_d, step;
    logic [CODE_W:0]   code_up;
    logic [3:0]        cnt_q, cnt_d;
    logic              lock_q, lock_d;
    logic              sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
    logic              filt_clr, filt_inc, filt_dec;
    logic              ovrd_en;
    logic [CODE_W-1:0] ovrd_code;

`ifdef DLY_LOCK_CTRL_OVRD_EN
    assign ovrd_en   = i_ovrd_en;
    assign ovrd_code = i_ovrd_code;
`else
    assign ovrd_en   = 1'b0;
    assign ovrd_code = CODE_RST;
`endif

    // Votes only accumulate while the loop is actively running.
    assign filt_clr = ovrd_en | i_load | ~i_en | (state_q == ST_IDLE);

    b_dly_vote_filt #(
        .P_TH (P_FILT_TH)
    ) u_vote_filt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_up   (i_pd_up),
        .i_dn   (i_pd_dn),
        .i_clr  (filt_clr),
        .o_inc  (filt_inc),
        .o_dec  (filt_dec)
    );

    assign step    = (state_q == ST_ACQ) ? STEP_ACQ : STEP_ONE;
    assign code_up = {1'b0, code_q} + {1'b0, step};

    // Next state, code, reversal bookkeeping and one-cycle saturation flags.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        new_dir  = DIR_NONE;
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;

        if (ovrd_en) begin
            state_d = ST_IDLE;
            code_d  = ovrd_code;
            cnt_d   = '0;
            dir_d   = DIR_NONE;
        end else if (i_load) begin
            state_d = i_en ? ST_ACQ : ST_IDLE;
            code_d  = i_init_code;
            cnt_d   = '0;
            dir_d   = DIR_NONE;
        end else if (!i_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dir_d   = DIR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                    cnt_d   = '0;
                    dir_d   = DIR_NONE;
                end
                ST_ACQ, ST_TRACK: begin
                    if (filt_inc || filt_dec) begin
                        if (filt_inc) begin
                            new_dir = DIR_UP;
                            if (code_up > {1'b0, CODE_MAX}) begin
                                code_d   = CODE_MAX;
                                sat_hi_d = 1'b1;
                            end else begin
                                code_d = code_up[CODE_W-1:0];
                            end
                        end else begin
                            new_dir = DIR_DN;
                            if (code_q < step) begin
                                code_d   = '0;
                                sat_lo_d = 1'b1;
                            end else begin
                                code_d = code_q - step;
                            end
                        end
                        if (state_q == ST_ACQ) begin
                            if (is_reversal(dir_q, new_dir)) begin
                                state_d = ST_TRACK;
                            end
                        end else if (is_reversal(dir_q, new_dir)) begin
                            cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                        end else begin
                            cnt_d = '0;
                        end
                        dir_d = new_dir;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    dir_d   = DIR_NONE;
                end
            endcase
        end

        lock_d = (cnt_d >= LOCK_REV);
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            code_q   <= CODE_RST;
            cnt_q    <= '0;
            dir_q    <= DIR_NONE;
            lock_q   <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            lock_q   <= lock_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
        end
    end

    assign o_dly_sel = code_q;
    assign o_lock    = lock_q;
    assign o_sat_hi  = sat_hi_q;
    assign o_sat_lo  = sat_lo_q;

endmodule

// File: tb/tb_b_dly_lock_ctrl.sv
// Directed bench for b_dly_lock_ctrl: expected outputs are queued when each
// cycle's stimulus is driven and compared after the clock edge.
module tb_b_dly_lock_ctrl;

    logic       clk = 1'b0;
    logic       i_rstn, i_en, i_load, i_pd_up, i_pd_dn;
    logic [8:0] i_init_code;
    logic [8:0] o_dly_sel;
    logic       o_lock, o_sat_hi, o_sat_lo;

    typedef struct {
        string tag;
        int    code;
        int    lock;
        int    hi;
        int    lo;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_code = 256;
    int   exp_lock = 0;

    always #5 clk = ~clk;

    b_dly_lock_ctrl dut (
        .i_clk       (clk),
        .i_rstn      (i_rstn),
        .i_en        (i_en),
        .i_load      (i_load),
        .i_init_code (i_init_code),
        .i_pd_up     (i_pd_up),
        .i_pd_dn     (i_pd_dn),
        .o_dly_sel   (o_dly_sel),
        .o_lock      (o_lock),
        .o_sat_hi    (o_sat_hi),
        .o_sat_lo    (o_sat_lo)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_assert++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue expectation, compare after the edge.
    // A negative hi/lo expectation means that flag is not checked.
    task automatic cyc(input logic en, input logic load, input int init,
                       input logic up, input logic dn, input string tag,
                       input int ec, input int el, input int eh, input int elo);
        exp_t e;
        i_en        = en;
        i_load      = load;
        i_init_code = init[8:0];
        i_pd_up     = up;
        i_pd_dn     = dn;
        e.tag = tag; e.code = ec; e.lock = el; e.hi = eh; e.lo = elo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq({e.tag, "/code"}, int'(o_dly_sel), e.code);
        check_eq({e.tag, "/lock"}, int'(o_lock), e.lock);
        if (e.hi >= 0) check_eq({e.tag, "/sat_hi"}, int'(o_sat_hi), e.hi);
        if (e.lo >= 0) check_eq({e.tag, "/sat_lo"}, int'(o_sat_lo), e.lo);
    endtask

    // n vote cycles; the update lands on the last one.
    task automatic votes(input int n, input logic up, input logic dn, input string tag,
                         input int new_code, input int new_lock, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) cyc(1'b1, 1'b0, 0, up, dn, tag, new_code, new_lock, hi, lo);
            else            cyc(1'b1, 1'b0, 0, up, dn, tag, exp_code, exp_lock, 0, 0);
        end
        exp_code = new_code;
        exp_lock = new_lock;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rstn = 1'b0;
        cyc(1'b1, 1'b1, 5, 1'b0, 1'b0, "reset", 256, 0, 0, 0);
        i_rstn = 1'b1;
        exp_code = 256; exp_lock = 0;

        // Acquisition: coarse steps of 8.
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, "enable", 256, 0, 0, 0);
        votes(4, 1'b1, 1'b0, "acq_up1", 264, 0, 0, 0);
        votes(4, 1'b1, 1'b0, "acq_up2", 272, 0, 0, 0);
        votes(4, 1'b0, 1'b1, "acq_rev", 264, 0, 0, 0);

        // Tracking: unit steps, lock on fourth reversal.
        votes(4, 1'b1, 1'b0, "trk_r1", 265, 0, 0, 0);
        votes(4, 1'b0, 1'b1, "trk_r2", 264, 0, 0, 0);
        votes(4, 1'b1, 1'b0, "trk_r3", 265, 0, 0, 0);
        votes(4, 1'b0, 1'b1, "trk_r4", 264, 1, 0, 0);
        votes(4, 1'b0, 1'b1, "trk_same1", 263, 0, 0, 0);
        votes(4, 1'b0, 1'b1, "trk_same2", 262, 0, 0, 0);

        // Relock, then drop enable mid-filter.
        votes(4, 1'b1, 1'b0, "relock_r1", 263, 0, 0, 0);
        votes(4, 1'b0, 1'b1, "relock_r2", 262, 0, 0, 0);
        votes(4, 1'b1, 1'b0, "relock_r3", 263, 0, 0, 0);
        votes(4, 1'b0, 1'b1, "relock_r4", 262, 1, 0, 0);
        votes(2, 1'b1, 1'b0, "pre_dis", 262, 1, 0, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, "disable", 262, 0, 0, 0);
        exp_lock = 0;

        // Simultaneous up/dn votes contribute nothing.
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, "reenable", 262, 0, 0, 0);
        votes(2, 1'b1, 1'b0, "both_a", 262, 0, 0, 0);
        votes(2, 1'b1, 1'b1, "both_b", 262, 0, 0, 0);
        votes(2, 1'b1, 1'b0, "both_c", 270, 0, 0, 0);

        // Fine-to-coarse carry.
        cyc(1'b1, 1'b1, 63, 1'b0, 1'b0, "ld63", 63, 0, 0, 0);
        exp_code = 63;
        votes(4, 1'b1, 1'b0, "carry_acq", 71, 0, 0, 0);
        votes(4, 1'b0, 1'b1, "carry_rev", 63, 0, 0, 0);
        votes(4, 1'b1, 1'b0, "carry_trk", 64, 0, 0, 0);
        check_eq("carry_coarse", int'(o_dly_sel[8:6]), 1);
        check_eq("carry_fine", int'(o_dly_sel[5:0]), 0);

        // Clamp at top and bottom.
        cyc(1'b1, 1'b1, 508, 1'b0, 1'b0, "ld508", 508, 0, 0, 0);
        exp_code = 508;
        votes(4, 1'b1, 1'b0, "clamp_hi1", 511, 0, -1, 0);
        votes(4, 1'b1, 1'b0, "clamp_hi2", 511, 0, 1, 0);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, "sat_hi_clr", 511, 0, 0, 0);
        cyc(1'b1, 1'b1, 3, 1'b0, 1'b0, "ld3", 3, 0, 0, 0);
        exp_code = 3;
        votes(4, 1'b0, 1'b1, "clamp_lo1", 0, 0, 0, -1);
        votes(4, 1'b0, 1'b1, "clamp_lo2", 0, 0, 0, 1);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, "sat_lo_clr", 0, 0, 0, 0);

        // Load beats a threshold vote and clears the filter.
        cyc(1'b1, 1'b1, 300, 1'b0, 1'b0, "ld300", 300, 0, 0, 0);
        exp_code = 300;
        votes(3, 1'b1, 1'b0, "prio_pre", 300, 0, 0, 0);
        cyc(1'b1, 1'b1, 100, 1'b1, 1'b0, "prio_load", 100, 0, 0, 0);
        exp_code = 100;
        votes(4, 1'b1, 1'b0, "prio_post", 108, 0, 0, 0);

        // Disable mid-filter: code held, filter restarts after re-enable.
        votes(2, 1'b1, 1'b0, "dis_pre", 108, 0, 0, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, "dis_mid", 108, 0, 0, 0);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, "dis_reen", 108, 0, 0, 0);
        votes(4, 1'b1, 1'b0, "dis_post", 116, 0, 0, 0);

        // Reset overrides load.
        i_rstn = 1'b0;
        cyc(1'b1, 1'b1, 5, 1'b1, 1'b0, "reset2", 256, 0, 0, 0);
        i_rstn = 1'b1;
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, "post_reset", 256, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
